uart_tx_buf: RTL

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: DEPTH-entry byte FIFO feeding an 8N1 UART transmitter.
// Bit timing comes from b_tick, a one-clk strobe at TICKS_PER_BIT per serial bit.
module uart_tx_buf #(
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned TICKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       b_tick,
   input  logic [7:0] tx_data,
   input  logic       tx_push,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          done_q, done_d;

   assign tx_full  = (count_q == COUNT_FULL);
   assign tx_empty = (count_q == '0);
   assign tx       = tx_q;
   assign tx_done  = done_q;
   assign tx_busy  = (state_q != IDLE);

   // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
   always_comb begin
      push_ok  = tx_push && !tx_full;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= tx_data;
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            tick_d = '0;
            bit_d  = '0;
            // Start bit launches on the pop edge, not on a b_tick.
            if (!tx_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (b_tick) begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  tx_d    = shift_q[0];
                  state_d = DATA;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (b_tick) begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (bit_q != 3'd7) begin
                     shift_d = {1'b0, shift_q[7:1]};
                     bit_d   = bit_q + 1'b1;
                     tx_d    = shift_q[1];
                  end else begin
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (b_tick) begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  tx_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
